dow_calc_seq: RTL and testbench

- Sequential, handshaked day-of-week engine for the calendar datapath.
- Accepts {date, month, year, calendar mode}, validates the date, and returns weekday plus an error code at a fixed latency.
- Generalises the combinational converter:
  - parametrised year width with full Gregorian century rule (no fixed century table);
  - optional Julian calendar;
  - Feb-29/day-range validation;
  - iterative divide-by-100 instead of combinational dividers.

---
 rtl/dow_pkg.sv | 60 ++++++
 rtl/dow_calc_seq_if.sv | 28 ++
 rtl/year_div100.sv | 64 ++++++
 rtl/dow_calc_seq.sv | 137 +++++++++++++
 tb/tb_dow_calc_seq.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dow_pkg.sv
// Shared definitions for the day-of-week engine: FSM state, weekday and
// error-code encodings, and the month lookup tables used by the SUM stage.
package dow_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDiv,
    StSum,
    StDone
  } dow_state_e;

  // Weekday encoding, 0 = Sunday.
  localparam logic [2:0] SUN = 3'd0;
  localparam logic [2:0] MON = 3'd1;
  localparam logic [2:0] TUE = 3'd2;
  localparam logic [2:0] WED = 3'd3;
  localparam logic [2:0] THU = 3'd4;
  localparam logic [2:0] FRI = 3'd5;
  localparam logic [2:0] SAT = 3'd6;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_MONTH = 2'd1;
  localparam logic [1:0] ERR_DAY   = 2'd2;
  localparam logic [1:0] ERR_YEAR  = 2'd3;

  // Remainder of a divide-by-100 always fits in 7 bits.
  localparam int unsigned REM_W = 7;

  // Month offset for the adjusted-year weekday sum, months 1..12.
  function automatic logic [2:0] month_offset(input logic [3:0] month);
    logic [2:0] t;
    case (month)
      4'd1:    t = 3'd0;
      4'd2:    t = 3'd3;
      4'd3:    t = 3'd2;
      4'd4:    t = 3'd5;
      4'd5:    t = 3'd0;
      4'd6:    t = 3'd3;
      4'd7:    t = 3'd5;
      4'd8:    t = 3'd1;
      4'd9:    t = 3'd4;
      4'd10:   t = 3'd6;
      4'd11:   t = 3'd2;
      4'd12:   t = 3'd4;
      default: t = 3'd0;
    endcase
    return t;
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] month, input logic leap);
    logic [4:0] n;
    case (month)
      4'd2:                      n = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   n = 5'd30;
      default:                   n = 5'd31;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/dow_calc_seq_if.sv
// Request/result handshake bundle for dow_calc_seq.
//   master: requester (drives request fields and out_ready)
//   slave : engine    (drives in_ready and the result fields)
interface dow_calc_seq_if #(
  parameter int unsigned YEAR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        date;
  logic [3:0]        month;
  logic [YEAR_W-1:0] year;
  logic              julian;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        day;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output in_valid, date, month, year, julian, out_ready,
    input  in_ready, out_valid, day, err, err_code
  );

  modport slave (
    input  in_valid, date, month, year, julian, out_ready,
    output in_ready, out_valid, day, err, err_code
  );
endinterface

// File: rtl/year_div100.sv
// Iterative restoring divider: dividend / 100, one quotient bit per cycle, MSB first.
//   clk, rst  : clock, async active-high reset
//   start     : load dividend and clear quotient/remainder
//   dividend  : value to divide
//   done      : high once YEAR_W iterations have completed, until next start
//   quotient  : dividend / 100
//   remainder : dividend % 100
module year_div100
  import dow_pkg::*;
#(
  parameter int unsigned YEAR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [YEAR_W-1:0] dividend,
  output logic              done,
  output logic [YEAR_W-1:0] quotient,
  output logic [REM_W-1:0]  remainder
);

  localparam int unsigned CntW = $clog2(YEAR_W + 1);

  logic [YEAR_W-1:0] dvd_q;
  logic [YEAR_W-1:0] quo_q;
  logic [REM_W-1:0]  rem_q;
  logic [CntW-1:0]   cnt_q;
  logic              done_q;
  logic [REM_W:0]    trial;
  logic              fits;

  // Partial remainder < 100, so the shifted trial value stays below 200.
  always_comb begin
    trial = {rem_q, dvd_q[YEAR_W-1]};
    fits  = trial >= (REM_W + 1)'(100);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      dvd_q  <= dividend;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= CntW'(YEAR_W);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= fits ? REM_W'(trial - (REM_W + 1)'(100)) : trial[REM_W-1:0];
      quo_q  <= {quo_q[YEAR_W-2:0], fits};
      dvd_q  <= dvd_q << 1;
      cnt_q  <= cnt_q - CntW'(1);
      done_q <= (cnt_q == CntW'(1));
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/dow_calc_seq.sv
// Sequential day-of-week engine with date validation.
//   clk, rst : clock, async active-high reset
//   bus      : dow_calc_seq_if slave; request {date, month, year, julian},
//              result {day, err, err_code} held with out_valid until out_ready.
// Flow: IDLE (accept) -> DIV (year/100, YEAR_W iterations) -> SUM (register result) -> DONE.
module dow_calc_seq
  import dow_pkg::*;
#(
  parameter int unsigned YEAR_W = 12,
  parameter int unsigned SUM_W  = YEAR_W + 2
) (
  input logic                  clk,
  input logic                  rst,
  dow_calc_seq_if.slave        bus
);

  dow_state_e        state_q;
  logic [4:0]        date_q;
  logic [3:0]        month_q;
  logic [YEAR_W-1:0] year_q;
  logic              julian_q;
  logic              out_valid_q;
  logic [2:0]        day_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic              accept;
  logic              div_done;
  logic [YEAR_W-1:0] q100;
  logic [REM_W-1:0]  r100;

  assign bus.in_ready = (state_q == StIdle) && !rst;
  assign accept       = bus.in_ready && bus.in_valid;

  // The divider loads straight from the bus on the accept edge.
  year_div100 #(
    .YEAR_W(YEAR_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .dividend (bus.year),
    .done     (div_done),
    .quotient (q100),
    .remainder(r100)
  );

  logic              leap;
  logic              adj;
  logic [YEAR_W-1:0] yp;
  logic [YEAR_W-1:0] yp_c;
  logic [SUM_W-1:0]  sum;
  logic [1:0]        ec_d;
  logic [2:0]        day_d;

  always_comb begin
    if (julian_q) begin
      leap = (year_q[1:0] == 2'd0);
    end else begin
      leap = (r100 != '0) ? (year_q[1:0] == 2'd0) : (q100[1:0] == 2'd0);
    end

    // Jan/Feb count as the tail of the previous year.
    adj  = (month_q < 4'd3);
    yp   = year_q - YEAR_W'(adj);
    yp_c = q100 - YEAR_W'(adj && (r100 == '0));

    if (julian_q) begin
      sum = SUM_W'(yp) + SUM_W'(yp >> 2) + SUM_W'(5)
          + SUM_W'(month_offset(month_q)) + SUM_W'(date_q);
    end else begin
      sum = SUM_W'(yp) + SUM_W'(yp >> 2) - SUM_W'(yp_c) + SUM_W'(yp_c >> 2)
          + SUM_W'(month_offset(month_q)) + SUM_W'(date_q);
    end

    if (month_q == 4'd0 || month_q > 4'd12) begin
      ec_d = ERR_MONTH;
    end else if (year_q == '0) begin
      ec_d = ERR_YEAR;
    end else if (date_q == 5'd0 || date_q > days_in_month(month_q, leap)) begin
      ec_d = ERR_DAY;
    end else begin
      ec_d = ERR_OK;
    end

    day_d = (ec_d != ERR_OK) ? SUN : 3'(sum % SUM_W'(7));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      date_q      <= '0;
      month_q     <= '0;
      year_q      <= '0;
      julian_q    <= 1'b0;
      out_valid_q <= 1'b0;
      day_q       <= SUN;
      err_q       <= 1'b0;
      err_code_q  <= ERR_OK;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            date_q   <= bus.date;
            month_q  <= bus.month;
            year_q   <= bus.year;
            julian_q <= bus.julian;
            state_q  <= StDiv;
          end
        end
        StDiv: begin
          if (div_done) state_q <= StSum;
        end
        StSum: begin
          out_valid_q <= 1'b1;
          day_q       <= day_d;
          err_q       <= (ec_d != ERR_OK);
          err_code_q  <= ec_d;
          state_q     <= StDone;
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.day       = day_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_dow_calc_seq.sv
module tb_dow_calc_seq;

  localparam int unsigned YW  = 12;
  localparam int          LAT = YW + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dow_calc_seq_if #(.YEAR_W(YW)) bus ();

  dow_calc_seq #(
    .YEAR_W(YW),
    .SUM_W (YW + 2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int d;
    int m;
    int y;
    int j;
    int dy;
    int e;
    int ec;
  } vec_t;

  // ---------------- reference model: day counting from 0001-01-01 ----------------
  function automatic bit is_leap(input int y, input int j);
    if (j != 0) return (y % 4) == 0;
    return ((y % 4) == 0 && (y % 100) != 0) || (y % 400) == 0;
  endfunction

  function automatic int dim(input int m, input int y, input int j);
    int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && is_leap(y, j)) return 29;
    return t[m-1];
  endfunction

  task automatic model(input int d, input int m, input int y, input int j,
                       output int dy, output int ec);
    int days;
    if (m < 1 || m > 12)            ec = 1;
    else if (y == 0)                ec = 3;
    else if (d < 1 || d > dim(m, y, j)) ec = 2;
    else                            ec = 0;
    dy = 0;
    if (ec == 0) begin
      days = 365 * (y - 1) + (y - 1) / 4;
      if (j == 0) days = days - (y - 1) / 100 + (y - 1) / 400;
      for (int k = 1; k < m; k++) days += dim(k, y, j);
      days += d;
      // Gregorian 0001-01-01 is a Monday, Julian 0001-01-01 a Saturday.
      dy = (j != 0) ? (days + 5) % 7 : days % 7;
    end
  endtask

  // ---------------- driver: one full request/response transaction ----------------
  task automatic run_req(input int d, input int m, input int y, input int j,
                         output int lat, output logic [2:0] dy, output logic e,
                         output logic [1:0] ec);
    @(negedge clk);
    bus.date     = 5'(d);
    bus.month    = 4'(m);
    bus.year     = YW'(y);
    bus.julian   = j[0];
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // Scramble inputs; the engine must use the captured values.
    bus.date     = 5'($urandom);
    bus.month    = 4'($urandom);
    bus.year     = YW'($urandom);
    bus.julian   = 1'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    dy = bus.day;
    e  = bus.err;
    ec = bus.err_code;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (bus.day !== 3'd0 || bus.err !== 1'b0 || bus.err_code !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_result: got day=%0d err=%b ec=%0d want 0/0/0",
               bus.day, bus.err, bus.err_code);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_in_rst: got %b want 0", bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready_idle: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t v[12];
    int lat;
    logic [2:0] dy;
    logic e;
    logic [1:0] ec;
    v = '{'{29, 2, 2024, 0, 4, 0, 0},
          '{29, 2, 1900, 0, 0, 1, 2},
          '{29, 2, 1900, 1, 2, 0, 0},
          '{29, 2, 2000, 0, 2, 0, 0},
          '{ 1, 1, 1900, 0, 1, 0, 0},
          '{15, 10, 1582, 0, 5, 0, 0},
          '{ 5, 10, 1582, 1, 5, 0, 0},
          '{ 1, 13, 2024, 0, 0, 1, 1},
          '{ 1, 1, 0, 0, 0, 1, 3},
          '{31, 4, 2024, 0, 0, 1, 2},
          '{ 1, 0, 0, 0, 0, 1, 1},
          '{ 0, 3, 2023, 0, 0, 1, 2}};
    foreach (v[i]) begin
      run_req(v[i].d, v[i].m, v[i].y, v[i].j, lat, dy, e, ec);
      n_checks++;
      if (lat !== LAT) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, LAT);
      end
      n_checks++;
      if (dy !== 3'(v[i].dy) || e !== v[i].e[0] || ec !== 2'(v[i].ec)) begin
        n_fail++;
        $display("FAIL directed_result[%0d] %0d-%0d-%0d j=%0d: got day=%0d err=%b ec=%0d want %0d/%0d/%0d",
                 i, v[i].y, v[i].m, v[i].d, v[i].j, dy, e, ec, v[i].dy, v[i].e, v[i].ec);
      end
    end
  endtask

  task automatic test_random();
    int d, m, y, j, lat, edy, eec;
    logic [2:0] dy;
    logic e;
    logic [1:0] ec;
    for (int i = 0; i < 150; i++) begin
      m = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
      y = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, (1 << YW) - 1);
      if ($urandom_range(0, 3) == 0) y = 100 * $urandom_range(1, 40);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 28);
      if ($urandom_range(0, 5) == 0) d = 29;
      j = $urandom_range(0, 1);
      model(d, m, y, j, edy, eec);
      run_req(d, m, y, j, lat, dy, e, ec);
      n_checks++;
      if (lat !== LAT || dy !== 3'(edy) || ec !== 2'(eec) || e !== (eec != 0)) begin
        n_fail++;
        $display("FAIL random[%0d] %0d-%0d-%0d j=%0d: got lat=%0d day=%0d err=%b ec=%0d want %0d/%0d/%b/%0d",
                 i, y, m, d, j, lat, dy, e, ec, LAT, edy, eec != 0, eec);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, edy, eec, bad;
    model(4, 7, 1776, 0, edy, eec);
    @(negedge clk);
    bus.date = 5'd4; bus.month = 4'd7; bus.year = YW'(1776); bus.julian = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL bp_latency: got %0d want %0d", lat, LAT);
    end
    // Offer a competing request while the result is held.
    bus.date = 5'd1; bus.month = 4'd1; bus.year = YW'(2001); bus.julian = 1'b0;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.day !== 3'(edy) || bus.in_ready !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    // in_valid still high: accepted on this edge, not the handshake edge.
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    model(1, 1, 2001, 0, edy, eec);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    n_checks++;
    if (lat !== LAT || bus.day !== 3'(edy) || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_next_req: got lat=%0d day=%0d err=%b want %0d/%0d/0",
               lat, bus.day, bus.err, LAT, edy);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    int lat, bad;
    logic [2:0] dy;
    logic e;
    logic [1:0] ec;
    // Leave a non-zero result in the output registers first.
    run_req(29, 2, 2024, 0, lat, dy, e, ec);
    @(negedge clk);
    bus.date = 5'd31; bus.month = 4'd12; bus.year = YW'(1999); bus.julian = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.day !== 3'd0 || bus.err !== 1'b0 ||
        bus.err_code !== 2'd0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got ov=%b day=%0d err=%b ec=%0d rdy=%b want 0/0/0/0/0",
               bus.out_valid, bus.day, bus.err, bus.err_code, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL async_no_stale: got %0d bad cycles want 0", bad);
    end
    run_req(31, 12, 1999, 0, lat, dy, e, ec);
    n_checks++;
    if (lat !== LAT || dy !== 3'd5 || e !== 1'b0 || ec !== 2'd0) begin
      n_fail++;
      $display("FAIL async_recover: got lat=%0d day=%0d err=%b ec=%0d want %0d/5/0/0",
               lat, dy, e, ec, LAT);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.date      = '0;
    bus.month     = '0;
    bus.year      = '0;
    bus.julian    = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
